tff_toggle_arbiter: RTL and testbench
=====================================

# tff_toggle_arbiter

Round-robin scheduler that shares a single toggle flip-flop output among N_REQ requesters. Each requester asks for a burst of LEN toggles on the shared output Q. The arbiter grants one requester at a time, runs the burst, and returns a completion pulse. It sits between the requester logic and the shared toggling resource and replaces direct per-requester toggle flip-flops.

## Interface
- N_REQ, 4: number of requesters; legal range 2..16.
- LEN_W, 8: width of each burst-length field.
- IDX_W, derived as clog2(N_REQ): width of the winner/pointer index; local only.

- CLK  input  1  clock; all state changes on its rising edge.
- RST  input  1  reset, asynchronous, active-low.
- REQ  input  N_REQ  per-requester request level. It is held until ACK is seen.
- LEN  input  N_REQ*LEN_W  burst length; requester i occupies bits [i*LEN_W +: LEN_W].
- GNT  output  N_REQ  one-hot grant, registered; high for the whole burst.
- ACK  output  N_REQ  one-hot completion pulse, registered, exactly 1 cycle.
- Q  output  1  shared toggling output, registered.
- BUSY  output  1  registered; high whenever state != IDLE.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE:**
  - If any REQ bit is high, select the winner W: the first index i with REQ[i]=1, searching PTR, PTR+1, … and wrapping modulo N_REQ.
  - Latch cnt <= LEN[W], set GNT[W] <= 1 and win <= W, go to RUN.
  - Otherwise hold.
- **RUN:**
  - If cnt != 0: Q <= ~Q, cnt <= cnt-1.
  - If cnt == 0: no toggle; GNT <= 0, ACK[win] <= 1, PTR <= (win+1) mod N_REQ, go to DONE.
- **DONE:** ACK <= 0, go to IDLE. REQ is ignored in DONE.
- Q is never cleared between bursts. Each burst starts from the current Q value.
- LEN = 0 is a legal burst: no toggles, GNT for 1 cycle, then ACK.
- REQ[W] dropping mid-burst is ignored; the burst always completes. There is no abort.
- LEN changes after the grant are ignored because the value is latched.
- REQ must be deasserted at the first edge after the requester samples ACK high. A REQ still high in the following IDLE cycle is a new request.
- Starvation freedom: after finishing W, the pointer moves past W. Every active requester is therefore served within N_REQ bursts.
- Reset, asynchronous at any time including mid-burst: Q=0, GNT=0, ACK=0, BUSY=0, cnt=0, PTR=0, win=0, state=IDLE. An interrupted burst produces no ACK.

## Timing
- REQ sampled high in IDLE at edge k:
  - GNT and BUSY go high after edge k.
  - Q toggles at edges k+1 … k+LEN.
  - GNT drops and ACK rises after edge k+LEN+1.
  - ACK drops and BUSY drops after edge k+LEN+2.
  - The earliest next grant is at edge k+LEN+3.
- Total resource occupancy is LEN+3 cycles per burst; back-to-back bursts have a 2-cycle gap with no toggles.
- Latency from REQ high, with the arbiter idle, to GNT is 1 edge.
- GNT and ACK are never high in the same cycle. At most one GNT bit and at most one ACK bit are high at any time.
- cnt is LEN_W bits wide and only decrements from a nonzero value, so it never wraps.

## Structure
- Shared include file tff_ctrl_defs.vh holds:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - the clog2 function.
- One sub-module: rr_pick.
  - Purely combinational.
  - Inputs: REQ and PTR. Outputs: valid and winner index.
  - Reusable by later arbiters in the codebase.
- Everything else (FSM, counter, Q register, pointer) lives in tff_toggle_arbiter.

## Test plan
- Reset, then REQ=4'b0001, LEN[0]=3:
  - GNT=0001 for 4 cycles.
  - Q goes 0→1→0→1.
  - ACK[0] pulses 1 cycle at edge k+4.
  - BUSY low at k+5.
  - Final Q=1.
- REQ=4'b1111 all held, all LEN=1, each requester dropping REQ after its ACK:
  - Grant order is 0,1,2,3.
  - Q toggles 4 times total, ending back at its start value.
  - PTR=0 at the end.
- LEN[2]=0, REQ=4'b0100:
  - GNT[2] high for exactly 1 cycle.
  - Q unchanged.
  - ACK[2] pulses on the following cycle.
- REQ=4'b0011 held continuously (never dropped), LEN=2:
  - Grants alternate 0,1,0,1.
  - Requester 0 is never granted twice in a row while REQ[1]=1.
- RST asserted low mid-burst (after 2 of 5 toggles on requester 1):
  - Q, GNT, ACK and BUSY go to 0 immediately, with no ACK.
  - After release, a new request for requester 3 is served first from PTR=0 (searching 0..3).
- REQ[0] dropped and LEN[0] changed from 4 to 9 during the burst:
  - Exactly 4 toggles occur.
  - ACK[0] is still issued.

Source files
------------

// File: rtl/tff_toggle_arbiter_pkg.sv
// Shared definitions for the toggle-arbiter slice: FSM state encodings and a
// constant clog2 helper for index widths.
package tff_toggle_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/tff_toggle_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i,
// wrapping modulo N_REQ.
module rr_pick
  import tff_toggle_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] win_o
);

  logic [IDX_W:0] idx;

  // Scan from the farthest offset down so the nearest hit is the last write.
  always_comb begin
    valid_o = 1'b0;
    win_o   = '0;
    idx     = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      idx = {1'b0, ptr_i} + (IDX_W + 1)'(off);
      if (idx >= (IDX_W + 1)'(N_REQ)) idx = idx - (IDX_W + 1)'(N_REQ);
      if (req_i[idx[IDX_W-1:0]]) begin
        valid_o = 1'b1;
        win_o   = idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/tff_toggle_arbiter.sv
// Round-robin arbiter sharing one toggle flip-flop among N_REQ requesters;
// each grant runs a latched burst of LEN toggles and ends with a one-cycle ACK.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | no burst; pick next requester from PTR and latch its length
//   ST_RUN  | GNT held; toggle Q while cnt != 0, then ACK the winner
//   ST_DONE | ACK high for this cycle; requests ignored
module tff_toggle_arbiter
  import tff_toggle_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int LEN_W = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [N_REQ-1:0]       REQ,
  input  logic [N_REQ*LEN_W-1:0] LEN,
  output logic [N_REQ-1:0]       GNT,
  output logic [N_REQ-1:0]       ACK,
  output logic                   Q,
  output logic                   BUSY
);

  localparam int IDX_W = clog2(N_REQ);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               q_q, q_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic               busy_q, busy_d;

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_win;
  logic [LEN_W-1:0]   len_arr [N_REQ];

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i   (REQ),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .win_o   (pick_win)
  );

  always_comb begin
    for (int i = 0; i < N_REQ; i++) len_arr[i] = LEN[i*LEN_W +: LEN_W];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    ptr_d   = ptr_q;
    win_d   = win_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          cnt_d           = len_arr[pick_win];
          gnt_d           = '0;
          gnt_d[pick_win] = 1'b1;
          win_d           = pick_win;
          state_d         = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_q != '0) begin
          q_d   = ~q_q;
          cnt_d = cnt_q - LEN_W'(1);
        end else begin
          gnt_d        = '0;
          ack_d[win_q] = 1'b1;
          ptr_d        = (win_q == IDX_W'(N_REQ - 1)) ? '0 : win_q + IDX_W'(1);
          state_d      = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      q_q     <= 1'b0;
      gnt_q   <= '0;
      ack_q   <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      busy_q  <= busy_d;
    end
  end

  assign GNT  = gnt_q;
  assign ACK  = ack_q;
  assign Q    = q_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_tff_toggle_arbiter.sv
// Directed bench for tff_toggle_arbiter (N_REQ=4, LEN_W=8) with
// hand-derived grant order, toggle counts and cycle timing.
module tb_tff_toggle_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           CLK;
  logic           RST;
  logic [N-1:0]   REQ;
  logic [N*W-1:0] LEN;
  logic [N-1:0]   GNT;
  logic [N-1:0]   ACK;
  logic           Q;
  logic           BUSY;

  int n_checks = 0;
  int n_fail   = 0;

  tff_toggle_arbiter #(.N_REQ(N), .LEN_W(W)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .REQ  (REQ),
    .LEN  (LEN),
    .GNT  (GNT),
    .ACK  (ACK),
    .Q    (Q),
    .BUSY (BUSY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_len(input int i, input logic [W-1:0] v);
    LEN[i*W +: W] = v;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    REQ = '0;
    step();
    step();
    RST = 1'b1;
    step();
  endtask

  // Waits for a grant, measures the burst and checks the ACK pulse.
  task automatic serve(input int idx, input int len, input bit drop,
                       input bit mutate, input string tag, output int lat);
    int   gcyc;
    int   tog;
    logic prev_q;
    lat  = 0;
    gcyc = 0;
    tog  = 0;
    while (GNT == '0 && lat < 40) begin
      step();
      lat++;
    end
    chk({tag, "_gnt"}, 32'(GNT), 32'(1) << idx);
    chk({tag, "_busy_run"}, 32'(BUSY), 32'd1);
    if (mutate) begin
      REQ[idx] = 1'b0;
      set_len(idx, 8'd9);
    end
    prev_q = Q;
    while (GNT != '0 && gcyc < 300) begin
      step();
      gcyc++;
      if (Q !== prev_q) tog++;
      prev_q = Q;
    end
    chk({tag, "_gnt_cycles"}, 32'(gcyc), 32'(len + 1));
    chk({tag, "_toggles"}, 32'(tog), 32'(len));
    chk({tag, "_ack"}, 32'(ACK), 32'(1) << idx);
    if (drop) REQ[idx] = 1'b0;
    step();
    chk({tag, "_ack_drop"}, 32'(ACK), 32'd0);
    chk({tag, "_busy_done"}, 32'(BUSY), 32'd0);
  endtask

  initial begin
    int   lat;
    int   w;
    logic q_start;

    RST = 1'b0;
    REQ = '0;
    LEN = '0;
    step();
    chk("rst_gnt", 32'(GNT), 32'd0);
    chk("rst_ack", 32'(ACK), 32'd0);
    chk("rst_q", 32'(Q), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    RST = 1'b1;
    step();

    // Single burst of 3 on requester 0: Q 0->1->0->1.
    set_len(0, 8'd3);
    REQ = 4'b0001;
    serve(0, 3, 1'b1, 1'b0, "t1", lat);
    chk("t1_latency", 32'(lat), 32'd1);
    chk("t1_final_q", 32'(Q), 32'd1);

    // All four requesting with LEN=1: order 0,1,2,3, Q back to start.
    do_reset();
    for (int i = 0; i < N; i++) set_len(i, 8'd1);
    q_start = Q;
    REQ = 4'b1111;
    for (int i = 0; i < N; i++) begin
      serve(i, 1, 1'b1, 1'b0, $sformatf("t2_%0d", i), lat);
      chk($sformatf("t2_lat_%0d", i), 32'(lat), 32'd1);
    end
    chk("t2_q_restored", 32'(Q), 32'(q_start));

    // Pointer wrapped to 0: requester 0 beats 3, then 3 is served.
    REQ = 4'b1001;
    serve(0, 1, 1'b1, 1'b0, "t2p_0", lat);
    serve(3, 1, 1'b1, 1'b0, "t2p_3", lat);

    // Zero-length burst on requester 2.
    set_len(2, 8'd0);
    q_start = Q;
    REQ = 4'b0100;
    serve(2, 0, 1'b1, 1'b0, "t3", lat);
    chk("t3_q_unchanged", 32'(Q), 32'(q_start));

    // Requests 0 and 1 held continuously: grants alternate 0,1,0,1.
    do_reset();
    for (int i = 0; i < N; i++) set_len(i, 8'd2);
    REQ = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      serve(i % 2, 2, 1'b0, 1'b0, $sformatf("t4_%0d", i), lat);
      chk($sformatf("t4_lat_%0d", i), 32'(lat), 32'd1);
    end
    REQ = '0;
    step();
    chk("t4_idle_gnt", 32'(GNT), 32'd0);

    // Async reset mid-burst after 2 of 5 toggles on requester 1.
    set_len(0, 8'd1);
    REQ = 4'b0001;
    serve(0, 1, 1'b1, 1'b0, "t5a", lat);
    chk("t5_q_pre", 32'(Q), 32'd1);
    set_len(1, 8'd5);
    REQ = 4'b0010;
    w = 0;
    while (GNT == '0 && w < 40) begin
      step();
      w++;
    end
    chk("t5_gnt", 32'(GNT), 32'b0010);
    step();
    step();
    chk("t5_q_mid", 32'(Q), 32'd1);
    chk("t5_busy_mid", 32'(BUSY), 32'd1);
    #2;
    RST = 1'b0;
    #1;
    chk("t5_rst_q", 32'(Q), 32'd0);
    chk("t5_rst_gnt", 32'(GNT), 32'd0);
    chk("t5_rst_ack", 32'(ACK), 32'd0);
    chk("t5_rst_busy", 32'(BUSY), 32'd0);
    REQ = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t5_no_ack_%0d", i), 32'(ACK), 32'd0);
    end
    RST = 1'b1;
    step();
    set_len(3, 8'd2);
    REQ = 4'b1000;
    serve(3, 2, 1'b1, 1'b0, "t5b", lat);
    chk("t5b_latency", 32'(lat), 32'd1);

    // REQ dropped and LEN rewritten mid-burst: still 4 toggles and an ACK.
    set_len(0, 8'd4);
    REQ = 4'b0001;
    serve(0, 4, 1'b1, 1'b1, "t6", lat);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
